// File: rtl/reg_op_sequencer_pkg.sv
// Shared opcodes, FSM states and helpers for the register-op sequencer.
// Optional READ_B skip path is enabled by REG_OP_SKIP_EN.
package reg_op_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ_A = 3'd1,
    S_READ_B = 3'd2,
    S_EXEC   = 3'd3,
    S_WRITE  = 3'd4
  } state_t;

  function automatic logic op_is_unary(input logic [2:0] op);
    return (op == OP_NOT) || (op == OP_SHL) || (op == OP_PASS);
  endfunction

endpackage

// File: rtl/reg_op_sequencer_if.sv
// Command handshake plus register-array bus of the sequencer.
// Master = sequencer side, slave = command source / array side.
interface reg_op_sequencer_if #(
  parameter int M = 4,
  parameter int N = 4
);
  logic         cmdValid;
  logic         cmdReady;
  logic [2:0]   cmdOp;
  logic [M-1:0] cmdA;
  logic [M-1:0] cmdB;
  logic [M-1:0] cmdDst;
  logic [M-1:0] readAddr;
  logic [N-1:0] rfData;
  logic [M-1:0] writeAddr;
  logic [N-1:0] writeData;
  logic         writeEnable;
  logic         done;
  logic         zero;
  logic         carry;

  modport master (
    input  cmdValid, cmdOp, cmdA, cmdB, cmdDst, rfData,
    output cmdReady, readAddr, writeAddr, writeData,
    output writeEnable, done, zero, carry
  );

  modport slave (
    output cmdValid, cmdOp, cmdA, cmdB, cmdDst, rfData,
    input  cmdReady, readAddr, writeAddr, writeData,
    input  writeEnable, done, zero, carry
  );
endinterface

// File: rtl/reg_op_sequencer_alu.sv
// Combinational ALU for the register-op sequencer.
// Arithmetic wraps modulo 2^N; carry is borrow for SUB.
module reg_op_alu
  import reg_op_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [2:0]   i_op,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_result,
  output logic         o_carry
);
  logic [N:0] w_sum;
  logic [N:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // Bit N of the extended difference is the unsigned borrow
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_result = i_a;
    o_carry  = 1'b0;
    unique case (i_op)
      OP_ADD:  {o_carry, o_result} = w_sum;
      OP_SUB:  {o_carry, o_result} = w_diff;
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_NOT:  o_result = ~i_a;
      OP_SHL: begin
        o_result = i_a << 1;
        o_carry  = i_a[N-1];
      end
      OP_PASS: o_result = i_a;
      default: o_result = i_a;
    endcase
  end
endmodule

// File: rtl/reg_op_sequencer.sv
// Multi-cycle register-to-register op sequencer (read A, read B, exec, write).
// Define REG_OP_SKIP_EN to skip READ_B for A==B or unary opcodes.
module reg_op_sequencer
  import reg_op_pkg::*;
#(
  parameter int M = 4,
  parameter int N = 4
) (
  input logic               clk,
  input logic               clr,
  reg_op_sequencer_if.master bus
);
  state_t       r_state;
  logic [2:0]   r_op;
  logic [M-1:0] r_b;
  logic [M-1:0] r_dst;
  logic [N-1:0] r_opA;
  logic [N-1:0] r_opB;
  logic         r_skip;
  logic         r_ready;
  logic [M-1:0] r_readAddr;
  logic [M-1:0] r_writeAddr;
  logic [N-1:0] r_writeData;
  logic         r_we;
  logic         r_done;
  logic         r_zero;
  logic         r_carry;

  logic [N-1:0] w_res;
  logic         w_carry;
  logic         w_skip;

`ifdef REG_OP_SKIP_EN
  assign w_skip = (bus.cmdA == bus.cmdB) || op_is_unary(bus.cmdOp);
`else
  assign w_skip = 1'b0;
`endif

  reg_op_alu #(.N(N)) u_alu (
    .i_op     (r_op),
    .i_a      (r_opA),
    .i_b      (r_opB),
    .o_result (w_res),
    .o_carry  (w_carry)
  );

  assign bus.cmdReady    = r_ready;
  assign bus.readAddr    = r_readAddr;
  assign bus.writeAddr   = r_writeAddr;
  assign bus.writeData   = r_writeData;
  assign bus.writeEnable = r_we;
  assign bus.done        = r_done;
  assign bus.zero        = r_zero;
  assign bus.carry       = r_carry;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= S_IDLE;
      r_op        <= OP_ADD;
      r_b         <= '0;
      r_dst       <= '0;
      r_opA       <= '0;
      r_opB       <= '0;
      r_skip      <= 1'b0;
      r_ready     <= 1'b1;
      r_readAddr  <= '0;
      r_writeAddr <= '0;
      r_writeData <= '0;
      r_we        <= 1'b0;
      r_done      <= 1'b0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.cmdValid && r_ready) begin
            r_op       <= bus.cmdOp;
            r_b        <= bus.cmdB;
            r_dst      <= bus.cmdDst;
            r_skip     <= w_skip;
            r_readAddr <= bus.cmdA;
            r_ready    <= 1'b0;
            r_state    <= S_READ_A;
          end
        end
        S_READ_A: begin
          r_opA <= bus.rfData;
          if (r_skip) begin
            r_opB   <= bus.rfData;
            r_state <= S_EXEC;
          end else begin
            r_readAddr <= r_b;
            r_state    <= S_READ_B;
          end
        end
        S_READ_B: begin
          r_opB   <= bus.rfData;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_writeData <= w_res;
          r_writeAddr <= r_dst;
          r_zero      <= (w_res == '0);
          r_carry     <= w_carry;
          r_we        <= 1'b1;
          r_done      <= 1'b1;
          r_state     <= S_WRITE;
        end
        S_WRITE: begin
          r_we    <= 1'b0;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_op_sequencer.sv
// Self-checking bench: array model plus arithmetic reference for the sequencer.
// Latency expectations follow REG_OP_SKIP_EN when defined.
module tb_reg_op_sequencer;
  localparam int M = 4;
  localparam int N = 4;
  localparam int MASK = (1 << N) - 1;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  reg_op_sequencer_if #(.M(M), .N(N)) bus ();
  reg_op_sequencer #(.M(M), .N(N)) dut (.clk(clk), .clr(clr), .bus(bus));

  logic [N-1:0] rf [16];
  logic [N-1:0] ref_rf [16];
  logic         pl_we = 1'b0;
  logic [M-1:0] pl_a = '0;
  logic [N-1:0] pl_d = '0;

  int checks = 0;
  int errors = 0;

  assign bus.rfData = rf[bus.readAddr];

  // Array samples its write port on the falling edge
  always @(negedge clk) begin
    if (bus.writeEnable) rf[bus.writeAddr] <= bus.writeData;
    else if (pl_we) rf[pl_a] <= pl_d;
  end

  function automatic void ref_op(input int op, input int a, input int b,
                                 output int res, output int c);
    int s;
    c = 0;
    case (op)
      0: begin s = a + b; res = s % (MASK + 1); c = (s > MASK) ? 1 : 0; end
      1: begin res = (a - b + MASK + 1) % (MASK + 1); c = (a < b) ? 1 : 0; end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = MASK - a;
      6: begin res = (a * 2) % (MASK + 1); c = (a * 2 > MASK) ? 1 : 0; end
      default: res = a;
    endcase
  endfunction

  function automatic int ref_wcyc(input int op, input int a, input int b);
`ifdef REG_OP_SKIP_EN
    if (a == b || op >= 5) return 3;
`endif
    return 4;
  endfunction

  task automatic drive(input int op, input int a, input int b, input int d);
    bus.cmdOp  = 3'(op);
    bus.cmdA   = M'(a);
    bus.cmdB   = M'(b);
    bus.cmdDst = M'(d);
  endtask

  task automatic preload(input int a, input int d);
    pl_a = M'(a);
    pl_d = N'(d);
    pl_we = 1'b1;
    @(negedge clk);
    #1 pl_we = 1'b0;
    ref_rf[a] = N'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input int op, input int a, input int b, input int d);
    int res, c, wc, g;
    g = 0;
    while (!bus.cmdReady && g < 20) begin
      @(posedge clk); #1; g++;
    end
    checks++;
    if (bus.cmdReady !== 1'b1) begin
      errors++; $display("FAIL ready_wait got %b exp 1", bus.cmdReady);
    end
    ref_op(op, int'(ref_rf[a]), int'(ref_rf[b]), res, c);
    wc = ref_wcyc(op, a, b);
    drive(op, a, b, d);
    bus.cmdValid = 1'b1;
    @(posedge clk); #1;
    bus.cmdValid = 1'b0;
    for (int k = 1; k <= wc + 1; k++) begin
      checks++;
      if (bus.cmdReady !== (k == wc + 1)) begin
        errors++; $display("FAIL ready c%0d got %b exp %b", k, bus.cmdReady, k == wc + 1);
      end
      checks++;
      if (bus.writeEnable !== (k == wc)) begin
        errors++; $display("FAIL we c%0d got %b exp %b", k, bus.writeEnable, k == wc);
      end
      checks++;
      if (bus.done !== (k == wc)) begin
        errors++; $display("FAIL done c%0d got %b exp %b", k, bus.done, k == wc);
      end
      if (k == 1 || k == 2) begin
        checks++;
        if (bus.readAddr !== M'((k == 2 && wc == 4) ? b : a)) begin
          errors++; $display("FAIL raddr c%0d got %0h a %0h b %0h", k, bus.readAddr, a, b);
        end
      end
      if (k == wc) begin
        checks++;
        if (bus.writeAddr !== M'(d) || bus.writeData !== N'(res)) begin
          errors++;
          $display("FAIL wport op%0d got %0h/%0h exp %0h/%0h", op,
                   bus.writeAddr, bus.writeData, d, res);
        end
        checks++;
        if (bus.carry !== 1'(c) || bus.zero !== (res == 0)) begin
          errors++;
          $display("FAIL flags op%0d got c%b z%b exp c%0d z%b", op,
                   bus.carry, bus.zero, c, res == 0);
        end
      end
      if (k == wc + 1) begin
        ref_rf[d] = N'(res);
        checks++;
        if (rf[d] !== N'(res)) begin
          errors++; $display("FAIL array r%0d got %0h exp %0h", d, rf[d], res);
        end
      end
      if (k <= wc) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    checks++;
    if (bus.cmdReady !== 1'b1 || bus.writeEnable !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl got r%b we%b d%b exp 1 0 0",
               bus.cmdReady, bus.writeEnable, bus.done);
    end
    checks++;
    if (bus.zero !== 1'b0 || bus.carry !== 1'b0) begin
      errors++; $display("FAIL reset_flags got z%b c%b exp 0 0", bus.zero, bus.carry);
    end
    checks++;
    if (bus.readAddr !== '0 || bus.writeAddr !== '0 || bus.writeData !== '0) begin
      errors++;
      $display("FAIL reset_bus got %0h %0h %0h exp 0 0 0",
               bus.readAddr, bus.writeAddr, bus.writeData);
    end
    for (int i = 0; i < 16; i++) preload(i, int'($urandom_range(MASK)));
  endtask

  task automatic test_plan();
    preload(1, 3);
    preload(2, 5);
    run_cmd(0, 1, 2, 4);
    run_cmd(1, 1, 2, 3);
    run_cmd(7, 3, 3, 9);
    preload(6, 9);
    preload(7, 7);
    run_cmd(0, 6, 7, 6);
  endtask

  task automatic test_clr_mid();
    int wes = 0;
    drive(0, 1, 2, 5);
    bus.cmdValid = 1'b1;
    @(posedge clk); #1;
    bus.cmdValid = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    checks++;
    if (bus.cmdReady !== 1'b1 || bus.zero !== 1'b0 || bus.carry !== 1'b0) begin
      errors++;
      $display("FAIL clr_mid got r%b z%b c%b exp 1 0 0", bus.cmdReady, bus.zero, bus.carry);
    end
    for (int i = 0; i < 6; i++) begin
      if (bus.writeEnable) wes++;
      @(posedge clk); #1;
    end
    checks++;
    if (wes != 0) begin
      errors++; $display("FAIL clr_we got %0d exp 0", wes);
    end
    checks++;
    if (rf[5] !== ref_rf[5]) begin
      errors++; $display("FAIL clr_array got %0h exp %0h", rf[5], ref_rf[5]);
    end
  endtask

  task automatic test_same_src();
    preload(1, 4);
    run_cmd(0, 1, 1, 2);
  endtask

  task automatic test_back_to_back();
    int op1, a1, b1, d1, op2, a2, b2, d2, wc1, r1, r2, c;
    int acc[$];
    int dones = 0;
    int bad = 0;
    op1 = int'($urandom_range(7)); a1 = int'($urandom_range(15));
    b1 = int'($urandom_range(15)); d1 = int'($urandom_range(15));
    op2 = int'($urandom_range(7)); a2 = int'($urandom_range(15));
    b2 = int'($urandom_range(15)); d2 = int'($urandom_range(15));
    wc1 = ref_wcyc(op1, a1, b1);
    ref_op(op1, int'(ref_rf[a1]), int'(ref_rf[b1]), r1, c);
    ref_rf[d1] = N'(r1);
    ref_op(op2, int'(ref_rf[a2]), int'(ref_rf[b2]), r2, c);
    ref_rf[d2] = N'(r2);
    drive(op1, a1, b1, d1);
    bus.cmdValid = 1'b1;
    for (int cy = 0; cy < 14; cy++) begin
      if (bus.done) dones++;
      if (bus.cmdReady && bus.cmdValid) acc.push_back(cy);
      if (cy >= 1 && cy <= wc1 && bus.cmdReady) bad++;
      @(posedge clk); #1;
      if (acc.size() == 1) drive(op2, a2, b2, d2);
      if (acc.size() == 2) bus.cmdValid = 1'b0;
    end
    bus.cmdValid = 1'b0;
    checks++;
    if (acc.size() != 2) begin
      errors++; $display("FAIL b2b_accepts got %0d exp 2", acc.size());
    end else begin
      checks++;
      if (acc[0] != 0 || acc[1] != wc1 + 1) begin
        errors++;
        $display("FAIL b2b_cycles got %0d,%0d exp 0,%0d", acc[0], acc[1], wc1 + 1);
      end
    end
    checks++;
    if (dones != 2 || bad != 0) begin
      errors++; $display("FAIL b2b_done got %0d ready_hi %0d exp 2 0", dones, bad);
    end
    checks++;
    if (rf[d1] !== ref_rf[d1] || rf[d2] !== ref_rf[d2]) begin
      errors++;
      $display("FAIL b2b_array got %0h %0h exp %0h %0h",
               rf[d1], rf[d2], ref_rf[d1], ref_rf[d2]);
    end
  endtask

  task automatic test_random(input int n);
    int op, a, b, d;
    for (int i = 0; i < n; i++) begin
      op = int'($urandom_range(7));
      a  = int'($urandom_range(15));
      b  = ($urandom_range(3) == 0) ? a : int'($urandom_range(15));
      d  = int'($urandom_range(15));
      repeat ($urandom_range(2)) begin
        @(posedge clk); #1;
      end
      run_cmd(op, a, b, d);
    end
  endtask

  initial begin
    bus.cmdValid = 1'b0;
    drive(0, 0, 0, 0);
    @(posedge clk); #1;
    test_reset();
    test_plan();
    test_clr_mid();
    test_same_src();
    test_back_to_back();
    test_random(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
